instr_fetch_sequencer: RTL



---
 rtl/instr_fetch_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through a 256x8 instruction memory,
// assembles 1- or 2-byte instructions and hands them to the decoder over valid/ready.
module instr_fetch_sequencer #(
  parameter logic [7:0]  RESET_PC      = 8'h00,
  parameter logic [15:0] TWO_BYTE_MASK = 16'h0F00,
  parameter logic [3:0]  HALT_OPCODE   = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [7:0]  imem_addr,
  input  logic [7:0]  imem_data,
  input  logic [7:0]  imem_next,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_opcode,
  output logic [7:0]  out_operand,
  output logic        out_len2,
  output logic [7:0]  out_pc,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_target,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] pc;

  logic [3:0] opcode_nib;
  logic       len2;
  logic       is_halt;
  logic       wrap_fault;
  logic       accept;
  logic       capture;

  assign imem_addr = pc;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    opcode_nib = imem_data[7:4];
    len2       = TWO_BYTE_MASK[opcode_nib];
    is_halt    = (opcode_nib == HALT_OPCODE);
    wrap_fault = len2 && (pc == 8'hFF);
    accept     = out_valid && out_ready;
    capture    = (state == ST_FETCH) && fetch_en && !redirect_valid &&
                 (!out_valid || out_ready);
  end

  // NOTE: state registers use non-blocking assignments so every update reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_opcode  <= 8'h00;
      out_operand <= 8'h00;
      out_len2    <= 1'b0;
      out_pc      <= 8'h00;
      halted      <= 1'b0;
      fault       <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      // An instruction flushed by a redirect in the same cycle never counts as accepted.
      if (accept && !redirect_valid) begin
        instr_count <= instr_count + 16'd1;
      end

      if (redirect_valid) begin
        pc        <= redirect_target;
        out_valid <= 1'b0;
        state     <= ST_FETCH;
        halted    <= 1'b0;
      end else if (capture) begin
        out_valid   <= 1'b1;
        out_opcode  <= imem_data;
        out_pc      <= pc;
        out_len2    <= len2;
        out_operand <= (len2 && !wrap_fault) ? imem_next : 8'h00;
        if (is_halt) begin
          state  <= ST_HALTED;
          halted <= 1'b1;
        end else if (wrap_fault) begin
          // Operand byte would lie past the end of memory: stop and flag it.
          pc     <= 8'h01;
          fault  <= 1'b1;
          state  <= ST_HALTED;
          halted <= 1'b1;
        end else begin
          pc <= pc + 8'd1 + {7'd0, len2};
        end
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
